// File: rtl/b14_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters,
// with variable-latency acknowledge and a timeout abort of stalled accesses.
module b14_mem_arbiter #(
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned DATA_W  = 31,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rq0_valid,
   input  logic              rq0_we,
   input  logic [ADDR_W-1:0] rq0_addr,
   input  logic [DATA_W-1:0] rq0_wdata,
   input  logic              rq1_valid,
   input  logic              rq1_we,
   input  logic [ADDR_W-1:0] rq1_addr,
   input  logic [DATA_W-1:0] rq1_wdata,
   output logic              rq0_ready,
   output logic              rq1_ready,
   output logic              rs0_valid,
   output logic              rs1_valid,
   output logic              rs_err,
   output logic [DATA_W-1:0] rs_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_we;
   logic              r_owner;
   logic              r_last_grant;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_rs0_valid;
   logic              r_rs1_valid;
   logic              r_rs_err;
   logic [DATA_W-1:0] r_rs_rdata;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic              w_we_nxt;
   logic              w_owner_nxt;
   logic              w_last_grant_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_rs0_valid_nxt;
   logic              w_rs1_valid_nxt;
   logic              w_rs_err_nxt;
   logic [DATA_W-1:0] w_rs_rdata_nxt;
   logic [ADDR_W-1:0] w_mem_addr_nxt;
   logic              w_mem_rd_nxt;
   logic              w_mem_wr_nxt;
   logic [DATA_W-1:0] w_mem_wdata_nxt;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   logic              w_cnt_done;

   // On a tie the requester that did not win last time is granted
   assign w_gnt0      = rq0_valid && (!rq1_valid || r_last_grant);
   assign w_gnt1      = rq1_valid && (!rq0_valid || !r_last_grant);
   assign w_sel_we    = w_gnt0 ? rq0_we    : rq1_we;
   assign w_sel_addr  = w_gnt0 ? rq0_addr  : rq1_addr;
   assign w_sel_wdata = w_gnt0 ? rq0_wdata : rq1_wdata;
   assign w_cnt_done  = (r_cnt == CNT_W'(TIMEOUT - 1));

   assign rs0_valid = r_rs0_valid;
   assign rs1_valid = r_rs1_valid;
   assign rs_err    = r_rs_err;
   assign rs_rdata  = r_rs_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign mem_wdata = r_mem_wdata;

   // State and registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_owner      <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
         r_rs0_valid  <= 1'b0;
         r_rs1_valid  <= 1'b0;
         r_rs_err     <= 1'b0;
         r_rs_rdata   <= '0;
         r_mem_addr   <= '0;
         r_mem_rd     <= 1'b0;
         r_mem_wr     <= 1'b0;
         r_mem_wdata  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_we         <= w_we_nxt;
         r_owner      <= w_owner_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_cnt        <= w_cnt_nxt;
         r_rs0_valid  <= w_rs0_valid_nxt;
         r_rs1_valid  <= w_rs1_valid_nxt;
         r_rs_err     <= w_rs_err_nxt;
         r_rs_rdata   <= w_rs_rdata_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_rd     <= w_mem_rd_nxt;
         r_mem_wr     <= w_mem_wr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
      end
   end

   // Next state; ack beats timeout on the final allowed cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_gnt0 || w_gnt1) w_state_nxt = S_ACCESS;
         S_ACCESS: if (mem_ack || w_cnt_done) w_state_nxt = S_RESP;
         S_RESP:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Ready (combinational) and next values of the registered outputs
   always_comb begin
      rq0_ready        = 1'b0;
      rq1_ready        = 1'b0;
      w_we_nxt         = r_we;
      w_owner_nxt      = r_owner;
      w_last_grant_nxt = r_last_grant;
      w_cnt_nxt        = r_cnt;
      w_rs0_valid_nxt  = 1'b0;
      w_rs1_valid_nxt  = 1'b0;
      w_rs_err_nxt     = 1'b0;
      w_rs_rdata_nxt   = r_rs_rdata;
      w_mem_addr_nxt   = '0;
      w_mem_rd_nxt     = 1'b0;
      w_mem_wr_nxt     = 1'b0;
      w_mem_wdata_nxt  = r_mem_wdata;
      case (r_state)
         S_IDLE: begin
            rq0_ready = w_gnt0 && !reset;
            rq1_ready = w_gnt1 && !reset;
            if (w_gnt0 || w_gnt1) begin
               w_we_nxt         = w_sel_we;
               w_owner_nxt      = w_gnt1;
               w_last_grant_nxt = w_gnt1;
               w_cnt_nxt        = '0;
               w_mem_addr_nxt   = w_sel_addr;
               w_mem_wdata_nxt  = w_sel_wdata;
               w_mem_rd_nxt     = !w_sel_we;
               w_mem_wr_nxt     = w_sel_we;
            end
         end
         S_ACCESS: begin
            if (mem_ack || w_cnt_done) begin
               w_rs0_valid_nxt = !r_owner;
               w_rs1_valid_nxt = r_owner;
               w_rs_err_nxt    = !mem_ack;
               w_rs_rdata_nxt  = (mem_ack && !r_we) ? mem_rdata : '0;
            end else begin
               w_cnt_nxt      = r_cnt + CNT_W'(1);
               w_mem_addr_nxt = r_mem_addr;
               w_mem_rd_nxt   = !r_we;
               w_mem_wr_nxt   = r_we;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_b14_mem_arbiter.sv
// Randomized bench for b14_mem_arbiter; a transaction-level model predicts
// grant order and the full per-transaction timeline from the chosen ack latency.
module tb_b14_mem_arbiter;
   localparam int unsigned ADDR_W = 20;
   localparam int unsigned DATA_W = 31;
   localparam int unsigned TO     = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              rq0_valid, rq0_we, rq1_valid, rq1_we;
   logic [ADDR_W-1:0] rq0_addr, rq1_addr;
   logic [DATA_W-1:0] rq0_wdata, rq1_wdata;
   logic              rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs_err;
   logic [DATA_W-1:0] rs_rdata, mem_wdata, mem_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd, mem_wr, mem_ack;

   int checks   = 0;
   int failures = 0;

   // Requester-side state: pending requests held until accepted
   bit                pv  [2];
   logic              pwe [2];
   logic [ADDR_W-1:0] pa  [2];
   logic [DATA_W-1:0] pd  [2];
   bit                m_last;
   bit                late_ack_due;

   always #5 clock = ~clock;

   b14_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
      .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
      .rq0_ready(rq0_ready), .rq1_ready(rq1_ready),
      .rs0_valid(rs0_valid), .rs1_valid(rs1_valid), .rs_err(rs_err), .rs_rdata(rs_rdata),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic new_req(input int r);
      pv[r]  = 1'b1;
      pwe[r] = 1'($urandom_range(0, 1));
      pa[r]  = ADDR_W'($urandom);
      pd[r]  = DATA_W'($urandom);
   endtask

   task automatic drive_rq();
      rq0_valid = pv[0]; rq0_we = pwe[0]; rq0_addr = pa[0]; rq0_wdata = pd[0];
      rq1_valid = pv[1]; rq1_we = pwe[1]; rq1_addr = pa[1]; rq1_wdata = pd[1];
   endtask

   // Idle-state outputs: everything low except rs_rdata/mem_wdata
   task automatic check_quiet(input string tag);
      chk({tag, ".rs0"},   rs0_valid, 0);
      chk({tag, ".rs1"},   rs1_valid, 0);
      chk({tag, ".err"},   rs_err,    0);
      chk({tag, ".rd"},    mem_rd,    0);
      chk({tag, ".wr"},    mem_wr,    0);
      chk({tag, ".addr"},  mem_addr,  0);
   endtask

   task automatic check_all_zero(input string tag);
      check_quiet(tag);
      chk({tag, ".rdy0"},  rq0_ready, 0);
      chk({tag, ".rdy1"},  rq1_ready, 0);
      chk({tag, ".rdata"}, rs_rdata,  0);
      chk({tag, ".wdata"}, mem_wdata, 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pv[0] = 1'b1; pv[1] = 1'b1;
      drive_rq();
      mem_ack = 1'b1;
      repeat (2) begin
         @(posedge clock); #1;
         check_all_zero("rst");
      end
      reset = 1'b0;
      pv[0] = 1'b0; pv[1] = 1'b0;
      drive_rq();
      mem_ack = 1'b0;
      m_last = 1'b1;
      late_ack_due = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clock); #1;
      drive_rq();
      mem_ack = late_ack_due ? 1'b1 : 1'($urandom_range(0, 1));
      late_ack_due = 1'b0;
      #1;
      chk("idle.rdy0", rq0_ready, 0);
      chk("idle.rdy1", rq1_ready, 0);
      check_quiet("idle");
   endtask

   // One transaction: ack arrives on ACCESS cycle k (k > TO means never)
   task automatic run_txn(input bit fill, input int k, input logic [DATA_W-1:0] rdata, input bit late);
      int g, n;
      bit abort;
      logic we;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d, exp_rd;
      if (fill) begin
         for (int r = 0; r < 2; r++)
            if (!pv[r] && $urandom_range(0, 9) < 6) new_req(r);
         if (!pv[0] && !pv[1]) new_req(int'($urandom_range(0, 1)));
      end
      @(posedge clock); #1;
      drive_rq();
      mem_ack = late_ack_due;
      late_ack_due = 1'b0;
      mem_rdata = DATA_W'($urandom);
      #1;
      g = (pv[0] && pv[1]) ? (m_last ? 0 : 1) : (pv[0] ? 0 : 1);
      chk("acc.rdy0", rq0_ready, g == 0);
      chk("acc.rdy1", rq1_ready, g == 1);
      check_quiet("acc");
      we = pwe[g]; a = pa[g]; d = pd[g];
      pv[g] = 1'b0;
      m_last = (g == 1);
      abort = (k > int'(TO));
      n = abort ? int'(TO) : k;
      for (int c = 1; c <= n; c++) begin
         @(posedge clock); #1;
         drive_rq();
         mem_ack = (c == k);
         mem_rdata = (c == k) ? rdata : DATA_W'($urandom);
         #1;
         chk("mem_rd",    mem_rd,    !we);
         chk("mem_wr",    mem_wr,    we);
         chk("mem_addr",  mem_addr,  a);
         chk("mem_wdata", mem_wdata, d);
         chk("bsy.rdy",   {rq0_ready, rq1_ready}, 0);
         chk("bsy.rs",    {rs0_valid, rs1_valid}, 0);
      end
      @(posedge clock); #1;
      drive_rq();
      mem_ack = 1'b0;
      mem_rdata = DATA_W'($urandom);
      #1;
      exp_rd = (abort || we) ? '0 : rdata;
      chk("rs0_valid", rs0_valid, g == 0);
      chk("rs1_valid", rs1_valid, g == 1);
      chk("rs_err",    rs_err,    abort);
      chk("rs_rdata",  rs_rdata,  exp_rd);
      chk("rsp.strb",  {mem_rd, mem_wr}, 0);
      chk("rsp.rdy",   {rq0_ready, rq1_ready}, 0);
      late_ack_due = abort && late;
   endtask

   task automatic reset_mid();
      pv[0] = 1'b0;
      new_req(1);
      @(posedge clock); #1;
      drive_rq();
      mem_ack = 1'b0;
      #1;
      chk("rm.rdy1", rq1_ready, 1);
      pv[1] = 1'b0;
      @(posedge clock); #1;
      drive_rq();
      #1;
      chk("rm.strb", {mem_rd, mem_wr}, {!pwe[1], pwe[1]});
      reset = 1'b1;
      mem_ack = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      mem_ack = 1'b0;
      drive_rq();
      #1;
      check_all_zero("rm");
      m_last = 1'b1;
      late_ack_due = 1'b0;
      idle_cycle();
      new_req(0); new_req(1);
      run_txn(1'b0, 2, DATA_W'($urandom), 1'b0);
   endtask

   initial begin
      pv[0] = 1'b0; pv[1] = 1'b0;
      pwe[0] = 1'b0; pwe[1] = 1'b0;
      pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
      mem_rdata = '0;
      do_reset();

      // Directed read from rq0, then write from rq1
      pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 20'h00123; pd[0] = DATA_W'($urandom);
      run_txn(1'b0, 1, 31'h2AAAAAAA, 1'b0);
      pv[1] = 1'b1; pwe[1] = 1'b1; pa[1] = 20'hFFFFF; pd[1] = 31'h7FFFFFFF;
      run_txn(1'b0, 3, DATA_W'($urandom), 1'b0);

      // Continuous contention after reset
      do_reset();
      for (int i = 0; i < 4; i++) begin
         for (int r = 0; r < 2; r++) if (!pv[r]) new_req(r);
         run_txn(1'b0, 1, DATA_W'($urandom), 1'b0);
      end
      run_txn(1'b0, 2, DATA_W'($urandom), 1'b0);

      // Timeout with a late ack, then ack on the final allowed cycle
      pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 20'h0ABCD; pd[0] = DATA_W'($urandom);
      run_txn(1'b0, int'(TO) + 5, DATA_W'($urandom), 1'b1);
      idle_cycle();
      idle_cycle();
      pv[0] = 1'b1; pwe[0] = 1'b0; pa[0] = 20'h05555; pd[0] = DATA_W'($urandom);
      run_txn(1'b0, int'(TO), 31'h1234567, 1'b0);

      reset_mid();

      // Random traffic
      for (int i = 0; i < 150; i++) begin
         int r, k;
         r = int'($urandom_range(0, 9));
         if (r < 2)       k = int'(TO) + 1 + int'($urandom_range(0, 3));
         else if (r == 2) k = int'(TO);
         else             k = 1 + int'($urandom_range(0, 5));
         if (!pv[0] && !pv[1] && $urandom_range(0, 3) == 0) idle_cycle();
         run_txn(1'b1, k, DATA_W'($urandom), 1'($urandom_range(0, 1)));
      end
      idle_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/b14_mem_arbiter.md
# b14_mem_arbiter

Two-port memory bus arbiter for the b14 core. It shares one 20-bit-address, 31-bit-data memory port between requester 0 (the b14 instruction/operand bus) and requester 1 (a program loader or debug host). Arbitration is round-robin, with a valid/ready request handshake and a single-cycle response pulse. It supports a variable-latency memory acknowledge and aborts a stalled access after a programmable number of cycles.

## Interface
- ADDR_W, 20, address width
- DATA_W, 31, data width
- TIMEOUT, 16, maximum ACCESS cycles without mem_ack before abort (≥1)
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  reset, synchronous, active-high
- rq0_valid / rq1_valid  in  1  request pending
- rq0_we / rq1_we  in  1  1 = write, 0 = read
- rq0_addr / rq1_addr  in  ADDR_W  request address
- rq0_wdata / rq1_wdata  in  DATA_W  write data
- rq0_ready / rq1_ready  out  1  request accepted this cycle (combinational)
- rs0_valid / rs1_valid  out  1  one-cycle completion pulse
- rs_err  out  1  completion was a timeout abort; valid with rsN_valid
- rs_rdata  out  DATA_W  read data; valid with rsN_valid
- mem_addr  out  ADDR_W  memory address
- mem_rd / mem_wr  out  1  memory read / write strobe, held until ack or abort
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory completion
- mem_rdata  in  DATA_W  read data, sampled when mem_ack=1

## Operation
- States: IDLE, ACCESS, RESP. Reset value is IDLE.
- IDLE behaviour:
  - A single requester with valid=1 is granted.
  - If both are valid, grant goes to the requester that is not last_grant.
  - The granted rqN_ready=1 in the same cycle.
  - On that edge the block latches we/addr/wdata, sets owner and last_grant to N, clears the counter, and moves to ACCESS.
  - With no valid request, all outputs are 0 (rs_rdata and mem_wdata hold their values).
- ACCESS behaviour:
  - mem_rd = !we, mem_wr = we; mem_addr and mem_wdata come from the latch.
  - The counter increments each cycle without ack.
  - If mem_ack=1: capture mem_rdata for a read or 0 for a write, set rs_err=0, go to RESP.
  - Otherwise, if the counter reaches TIMEOUT-1: capture rdata=0, set rs_err=1, go to RESP.
  - If ack arrives on the final allowed cycle, ack takes priority over timeout.
- RESP behaviour:
  - rs{owner}_valid=1 for exactly one cycle, together with rs_err and rs_rdata.
  - mem_rd and mem_wr are 0.
  - Next state is IDLE.
  - No response backpressure.
- rqN_ready is 0 in ACCESS and RESP. Requesters hold valid/addr/we/wdata stable until ready.
- mem_ack is ignored outside ACCESS. A late ack arriving after an abort is dropped.
- Reset:
  - Outputs reset to 0: rq*_ready, rs*_valid, rs_err, rs_rdata, mem_addr, mem_rd, mem_wr, mem_wdata.
  - last_grant=1, so requester 0 wins the first tie. Counter=0, state IDLE.
  - Reset mid-ACCESS drops the transaction with no response pulse.
- The counter width is sufficient for TIMEOUT-1 and never wraps.

## Timing
- rq ready asserted in cycle T; mem strobe is high from T+1.
- Ack seen at cycle T+k (k≥1) gives rsN_valid at T+k+1.
- Minimum transaction is 3 cycles (accept, ACCESS with immediate ack, RESP). The next accept is at T+3 at the earliest.
- Abort: strobe is high for TIMEOUT cycles (T+1..T+TIMEOUT) and rs_err pulses at T+TIMEOUT+1.
- mem_* and rs* are registered. rqN_ready is the only combinational output (from state, rq*_valid, last_grant).
- Under continuous contention, grants alternate 0,1,0,1. Neither requester waits more than one transaction.

## Test plan
- Single read, rq0_addr=0x00123, memory acks 1 cycle after strobe with mem_rdata=0x2AAAAAAA -> rq0_ready at T, mem_rd=1 at T+1, rs0_valid=1, rs_err=0, rs_rdata=0x2AAAAAAA at T+2.
- Write from rq1: addr=0xFFFFF, wdata=0x7FFFFFFF, ack after 3 cycles -> mem_wr=1 for 3 cycles with mem_addr=0xFFFFF and mem_wdata=0x7FFFFFFF; rs1_valid with rs_rdata=0, rs_err=0.
- Both valid every cycle for 4 transactions after reset -> grant order 0,1,0,1; each rsN_valid goes to the correct owner.
- No ack, TIMEOUT=16 -> mem_rd high exactly 16 cycles; rs0_valid with rs_err=1, rs_rdata=0; an ack injected 2 cycles later is ignored and produces no second response.
- Ack on the 16th ACCESS cycle -> normal completion with rs_err=0 (ack beats timeout).
- Reset asserted during ACCESS -> next cycle shows all outputs 0 and state IDLE, with no rs pulse. With both requesters then valid, requester 0 is granted first.
